// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning the architectural HI/LO registers
// Ports: clk; reset_n (async, active-low); start/op/a/b launch mult(0)/multu(1)/div(2)/divu(3), 4-7 act as mult;
//        hi_write/lo_write load a into HI/LO when idle; busy high while an op is in flight; hi/lo committed values.
module mult_div_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_write,
    input  logic        lo_write,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_LAT = MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          ok_q, ok_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          is_div, is_signed, idle, fire, commit, neg_a, neg_b;
    logic [63:0]   ma, mb, prod;
    logic [31:0]   da, db, q_mag, r_mag, quo, rem, res_hi, res_lo;

    assign is_div    = op == 3'd2 || op == 3'd3;
    assign is_signed = !(op == 3'd1 || op == 3'd3);

    // One 64x64 multiplier serves both flavours: the low 64 bits of the
    // sign- or zero-extended product are the exact 32x32 result.
    assign ma   = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
    assign mb   = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
    assign prod = ma * mb;

    // Signed division runs on magnitudes through the unsigned divider, so
    // 0x80000000 / -1 needs no special case: its magnitude quotient negates to itself.
    assign neg_a = is_signed & a[31];
    assign neg_b = is_signed & b[31];
    assign da    = neg_a ? -a : a;
    assign db    = neg_b ? -b : b;
    assign q_mag = da / db;
    assign r_mag = da % db;
    assign quo   = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem   = neg_a ? -r_mag : r_mag;

    assign res_hi = is_div ? rem : prod[63:32];
    assign res_lo = is_div ? quo : prod[31:0];

    assign idle   = cnt_q == '0;
    assign fire   = idle & start;
    // A divide by zero still runs its full latency but never commits.
    assign commit = cnt_q == CW'(1) && ok_q;

    always_comb begin
        cnt_d     = fire ? (is_div ? CW'(DIV_LAT) : CW'(MULT_LAT)) : idle ? '0 : cnt_q - CW'(1);
        pend_hi_d = fire ? res_hi : pend_hi_q;
        pend_lo_d = fire ? res_lo : pend_lo_q;
        ok_d      = fire ? !(is_div && b == 32'd0) : ok_q;
        hi_d      = commit ? pend_hi_q : (idle && !start && hi_write) ? a : hi_q;
        lo_d      = commit ? pend_lo_q : (idle && !start && lo_write) ? a : lo_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            ok_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            ok_q      <= ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = cnt_q != '0;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;
    int          checks = 0;
    int          errors = 0;
    int          n;

    mult_div_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .hi_write(hi_write), .lo_write(lo_write), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge with busy low.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int cnt);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        wait_idle(cnt);
    endtask

    task automatic write_reg(input logic h, input logic [31:0] v);
        hi_write = h; lo_write = !h; a = v;
        @(negedge clk);
        hi_write = 1'b0; lo_write = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        write_reg(1'b1, 32'h55);
        write_reg(1'b0, 32'h66);
        check("pre_hi", hi, 32'h55);
        check("pre_lo", lo, 32'h66);

        // reset on busy cycle 2 discards the op
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("mid_busy1", busy, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("nocommit_busy", busy, 0);
        check("nocommit_lo", lo, 0);

        run(3'd0, 32'hFFFFFFFE, 32'd3, n);
        check("mult_lat", n, 5);
        check("mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run(3'd1, 32'hFFFFFFFE, 32'd3, n);
        check("multu_lat", n, 5);
        check("multu", {hi, lo}, 64'h00000002_FFFFFFFA);
        run(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        check("op5_mult", {hi, lo}, 64'h00000000_00000001);

        run(3'd2, 32'hFFFFFFF9, 32'd2, n);
        check("div_lat", n, 10);
        check("div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run(3'd3, 32'd7, 32'd2, n);
        check("divu_lat", n, 10);
        check("divu", {hi, lo}, 64'h00000001_00000003);
        run(3'd3, 32'hFFFFFFF9, 32'd2, n);
        check("divu_big", {hi, lo}, 64'h00000001_7FFFFFFC);

        write_reg(1'b1, 32'h11);
        write_reg(1'b0, 32'h22);
        run(3'd2, 32'd100, 32'd0, n);
        check("div0_lat", n, 10);
        check("div0", {hi, lo}, 64'h00000011_00000022);

        write_reg(1'b1, 32'hABCD);
        check("mthi", {hi, lo}, 64'h0000ABCD_00000022);
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3; hi_write = 1'b1;
        @(negedge clk);
        start = 1'b0; hi_write = 1'b0;
        check("wr_busy1", busy, 1);
        check("start_wins", hi, 32'hABCD);
        lo_write = 1'b1; a = 32'hDEAD;
        @(negedge clk);
        lo_write = 1'b0;
        check("mtlo_busy", lo, 32'h22);
        wait_idle(n);
        check("wr_lat", n + 1, 5);
        check("wr_mult", {hi, lo}, 64'h00000000_00000006);

        start = 1'b1; op = 3'd2; a = 32'h80000000; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        check("ovf_lat", n + 3, 10);
        check("ovf_div", {hi, lo}, 64'h00000000_80000000);
        run(3'd0, 32'd7, 32'd6, n);
        check("b2b_lat", n, 5);
        check("b2b_mult", {hi, lo}, 64'h00000000_0000002A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
